fpd_iterative: RTL and testbench

Iterative single-precision (IEEE-754 binary32 layout) floating-point divider, the inverse of the team's combinational FP32 multiplier in the arithmetic-chip datapath. It computes quotient = A / B with a radix-2 restoring mantissa divider, one quotient bit per clock. It uses the same number conventions as the multiplier: hidden-1 mantissas, truncation (no rounding), and no denormal support. A start/busy/done handshake lets the chip's test controller launch one division at a time.

---
 rtl/fpd_iterative.sv | 143 ++++++++++++++
 tb/tb_fpd_iterative.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpd_iterative.sv
// Iterative FP32 divider: radix-2 restoring mantissa division, one quotient bit
// per clock, truncating, no denormals (exponent field 0 is treated as zero).
module fpd_iterative (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] quotient,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [23:0]        mb_q, mb_d;
  logic [24:0]        r_q, r_d, q_q, q_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               spec_q, spec_d, spec_dz_q, spec_dz_d;
  logic [31:0]        quot_q, quot_d;
  logic               dbz_q, dbz_d, ovf_q, ovf_d;

  logic               a_zero, b_zero, geq;
  logic [24:0]        r_sub, r_keep;
  logic signed [9:0]  e_base, e_n;
  logic [22:0]        frac;

  assign a_zero = (A[30:23] == 8'd0);
  assign b_zero = (B[30:23] == 8'd0);
  assign geq    = (r_q >= {1'b0, mb_q});
  assign r_sub  = r_q - {1'b0, mb_q};
  assign r_keep = geq ? r_sub : r_q;

  assign e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
  assign e_n    = q_q[24] ? e_base : e_base - 10'sd1;
  assign frac   = q_q[24] ? q_q[23:1] : q_q[22:0];

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    mb_d      = mb_q;
    r_d       = r_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    spec_d    = spec_q;
    spec_dz_d = spec_dz_q;
    quot_d    = quot_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    case (state_q)
      DIVIDE: begin
        q_d   = {q_q[23:0], geq};
        // r_keep < mb < 2^24 here, so bit 24 is always clear before the shift
        r_d   = {r_keep[23:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = NORM;
      end
      NORM: begin
        state_d = DONE;
        if (spec_q) begin
          if (spec_dz_q) begin
            quot_d = {sign_q, 8'hFF, 23'd0};
            dbz_d  = 1'b1;
          end else begin
            quot_d = '0;
          end
        end else if (e_n >= 10'sd255) begin
          quot_d = {sign_q, 8'hFF, 23'd0};
          ovf_d  = 1'b1;
        end else if (e_n <= 10'sd0) begin
          quot_d = '0;
        end else begin
          quot_d = {sign_q, e_n[7:0], frac};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Both IDLE and DONE are not-busy, so either may accept a new operation.
    if (start && (state_q == IDLE || state_q == DONE)) begin
      state_d   = (a_zero || b_zero) ? NORM : DIVIDE;
      sign_d    = A[31] ^ B[31];
      ea_d      = A[30:23];
      eb_d      = B[30:23];
      mb_d      = {1'b1, B[22:0]};
      r_d       = {2'b01, A[22:0]};
      q_d       = '0;
      cnt_d     = '0;
      spec_d    = a_zero || b_zero;
      spec_dz_d = b_zero;
      dbz_d     = 1'b0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      mb_q      <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      spec_q    <= 1'b0;
      spec_dz_q <= 1'b0;
      quot_q    <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      mb_q      <= mb_d;
      r_q       <= r_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      spec_q    <= spec_d;
      spec_dz_q <= spec_dz_d;
      quot_q    <= quot_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q == DIVIDE) || (state_q == NORM);

endmodule

// File: tb/tb_fpd_iterative.sv
// Bench for fpd_iterative: vector table plus randomised operands checked through
// a scoreboard queue, and hand sequences for back-to-back, ignored start and reset.
module tb_fpd_iterative;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] A, B;
  logic [31:0] quotient;
  logic        done, busy, div_by_zero, overflow;

  fpd_iterative dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .quotient   (quotient),
    .done       (done),
    .busy       (busy),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dz;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic        dz;
    logic        ov;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer quotient via 64-bit division, then pack.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t        v;
    logic [63:0] ma, mb, qq;
    logic [22:0] fr;
    logic [31:0] eb32;
    int          e;
    logic        s;
    v.a  = a;
    v.b  = b;
    v.dz = 1'b0;
    v.ov = 1'b0;
    s    = a[31] ^ b[31];
    if (b[30:23] == 8'd0) begin
      v.q  = {s, 8'hFF, 23'd0};
      v.dz = 1'b1;
    end else if (a[30:23] == 8'd0) begin
      v.q = 32'h0;
    end else begin
      ma = {40'd0, 1'b1, a[22:0]};
      mb = {40'd0, 1'b1, b[22:0]};
      qq = (ma << 24) / mb;
      e  = {24'd0, a[30:23]};
      eb32 = {24'd0, b[30:23]};
      e  = e - int'(eb32) + 127;
      if (qq[24]) fr = qq[23:1];
      else begin
        fr = qq[22:0];
        e  = e - 1;
      end
      if (e >= 255) begin
        v.q  = {s, 8'hFF, 23'd0};
        v.ov = 1'b1;
      end else if (e <= 0) v.q = 32'h0;
      else v.q = {s, e[7:0], fr};
    end
    return v;
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic dz, input logic ov);
    exp_t e;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    e.q   = q;
    e.dz  = dz;
    e.ov  = ov;
    e.lat = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 1 : 26;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Counts edges since the accepting edge until done rises (bounded).
  task automatic wait_done(input int elapsed, input bit check_pulse);
    exp_t e;
    int   n;
    n = elapsed;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got done with no pending op, required a pending op");
      return;
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("quotient", quotient, e.q);
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
    chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    if (check_pulse) begin
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("quotient_held", quotient, e.q);
      chk("flags_held", {30'd0, div_by_zero, overflow}, {30'd0, e.dz, e.ov});
    end
  endtask

  vec_t tbl[12];
  vec_t v;
  exp_t junk;
  bit   seen;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", quotient, 32'h0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(negedge clk) rst = 1'b0;

    tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0};
    tbl[2]  = '{32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0, 1'b0};
    tbl[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0};
    tbl[4]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
    tbl[5]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b1};
    tbl[6]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0};
    tbl[7]  = '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0};
    tbl[8]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0};
    tbl[9]  = '{32'h00400000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
    tbl[10] = '{32'h7FC00000, 32'h7F800000, 32'h3FC00000, 1'b0, 1'b0};
    tbl[11] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].dz, tbl[i].ov);
      wait_done(0, 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i < 6) begin
        ra[30:23] = 8'($urandom_range(90, 160));
        rb[30:23] = 8'($urandom_range(90, 160));
      end
      v = model(ra, rb);
      launch(v.a, v.b, v.q, v.dz, v.ov);
      wait_done(0, 1'b1);
    end

    // back-to-back: start during the done cycle
    launch(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    wait_done(0, 1'b0);
    launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0);
    wait_done(0, 1'b1);
    launch(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0);
    wait_done(0, 1'b0);
    launch(32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0, 1'b0);
    wait_done(0, 1'b1);

    // start pulsed at edge 10 of a running division is ignored
    launch(32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    A     = 32'h3F800000;
    B     = 32'h00000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(10, 1'b1);

    // reset at edge 15 aborts the division
    launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_quotient", quotient, 32'h0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    junk = sb.pop_front();
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("no_done_after_reset", {31'd0, seen}, 32'd0);
    launch(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    wait_done(0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
